// File: rtl/ffs_if.sv
// ffs_if: operand/result bundle for the GF(2^255-19) subtractor.
//   start      - request pulse from the sequencer
//   a_i, b_i   - 255-bit minuend / subtrahend
//   out        - 255-bit registered difference
//   done       - one-cycle completion pulse
//   busy       - operation in flight
interface ffs_if;
    logic         start;
    logic [254:0] a_i;
    logic [254:0] b_i;
    logic [254:0] out;
    logic         done;
    logic         busy;

    modport master (
        output start, a_i, b_i,
        input  out, done, busy
    );

    modport slave (
        input  start, a_i, b_i,
        output out, done, busy
    );
endinterface

// File: rtl/ffs.sv
// ffs: limb-serial modular subtractor, out = (a_i - b_i) mod p, p = 2^255 - 19.
// One 64-bit subtractor walks the four limbs in S1..S4. One 64-bit adder trails
// it by one state, building d + p in S2..S5. At the S5 edge the final borrow
// picks d (a >= b) or d + p (a < b).
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - ffs_if slave: start/a_i/b_i in, out/done/busy out
module ffs #(
    parameter logic [255:0] P      = 256'h7fff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffed,
    parameter int unsigned  LIMB_W = 64
) (
    input  logic  clk,
    input  logic  rst,
    ffs_if.slave  bus
);

    typedef enum logic [2:0] {StIdle, StS1, StS2, StS3, StS4, StS5} state_e;

    state_e       state_q, state_d;
    logic [255:0] a_q, a_d;
    logic [255:0] b_q, b_d;
    logic [255:0] d_q, d_d;
    logic [255:0] s_q, s_d;
    logic         bw_q, bw_d;
    logic         cy_q, cy_d;
    logic [254:0] out_q, out_d;
    logic         done_q, done_d;
    logic         busy_q, busy_d;

    logic [2:0]        st_raw;
    logic [1:0]        sub_idx, add_idx;
    logic [7:0]        sub_lo, add_lo;
    logic [LIMB_W-1:0] sub_res, add_res;
    logic              sub_bo, add_co;

    // The subtractor works on limb state-1, the adder on limb state-2.
    // LIMB_W is fixed at 64, so the bit offset is the limb index shifted by 6.
    assign st_raw  = state_q;
    assign sub_idx = 2'(st_raw - 3'd1);
    assign add_idx = 2'(st_raw - 3'd2);
    assign sub_lo  = {sub_idx, 6'b0};
    assign add_lo  = {add_idx, 6'b0};

    // 65-bit forms: bit 64 is the borrow-out / carry-out.
    assign {sub_bo, sub_res} = {1'b0, a_q[sub_lo +: LIMB_W]}
                             - {1'b0, b_q[sub_lo +: LIMB_W]}
                             - {{LIMB_W{1'b0}}, bw_q};
    assign {add_co, add_res} = {1'b0, d_q[add_lo +: LIMB_W]}
                             + {1'b0, P[add_lo +: LIMB_W]}
                             + {{LIMB_W{1'b0}}, cy_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        d_d     = d_q;
        s_d     = s_q;
        bw_d    = bw_q;
        cy_d    = cy_q;
        out_d   = out_q;
        done_d  = 1'b0;
        busy_d  = busy_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_d     = {1'b0, bus.a_i};
                    b_d     = {1'b0, bus.b_i};
                    bw_d    = 1'b0;
                    cy_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = StS1;
                end
            end
            StS1, StS2, StS3, StS4: begin
                d_d[sub_lo +: LIMB_W] = sub_res;
                bw_d                  = sub_bo;
                if (state_q != StS1) begin
                    s_d[add_lo +: LIMB_W] = add_res;
                    cy_d                  = add_co;
                end
                state_d = state_e'(st_raw + 3'd1);
            end
            StS5: begin
                // bw_q now holds the limb-3 borrow: set means a < b, add p back.
                out_d   = bw_q ? {add_res[LIMB_W-2:0], s_q[191:0]} : d_q[254:0];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            s_q     <= '0;
            bw_q    <= 1'b0;
            cy_q    <= 1'b0;
            out_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
            s_q     <= s_d;
            bw_q    <= bw_d;
            cy_q    <= cy_d;
            out_q   <= out_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_ffs.sv
module tb_ffs;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ffs_if bus ();

    ffs dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [255:0] p_full;
    logic [254:0] pv;

    task automatic chk(input string tag, input logic [254:0] got, input logic [254:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issue one op and check busy/done each cycle, the result at E5 and its hold.
    task automatic do_op(input logic [254:0] a, input logic [254:0] b,
                         input logic [254:0] exp, input string tag);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a_i   = a;
        bus.b_i   = b;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk({tag, "_busy"}, 255'(bus.busy), 255'd1);
            chk({tag, "_nodone"}, 255'(bus.done), 255'd0);
            @(negedge clk);
        end
        chk({tag, "_done"}, 255'(bus.done), 255'd1);
        chk({tag, "_idle"}, 255'(bus.busy), 255'd0);
        chk({tag, "_out"}, bus.out, exp);
        @(negedge clk);
        chk({tag, "_done_low"}, 255'(bus.done), 255'd0);
        chk({tag, "_hold"}, bus.out, exp);
    endtask

    initial begin
        p_full    = (256'd1 << 255) - 256'd19;
        pv        = p_full[254:0];
        bus.start = 1'b0;
        bus.a_i   = '0;
        bus.b_i   = '0;

        repeat (2) @(negedge clk);
        chk("rst_out", bus.out, 255'd0);
        chk("rst_busy", 255'(bus.busy), 255'd0);
        chk("rst_done", 255'(bus.done), 255'd0);
        rst = 1'b0;

        do_op(255'd5, 255'd3, 255'd2, "5m3");
        do_op(255'd3, 255'd5, pv - 255'd2, "3m5");
        do_op(255'd0, 255'd1, pv - 255'd1, "0m1");
        do_op(255'd0, 255'd0, 255'd0, "0m0");
        do_op(pv - 255'd1, 255'd0, pv - 255'd1, "pm1m0");
        do_op(pv - 255'd1, pv - 255'd1, 255'd0, "pm1mpm1");
        do_op(255'd1 << 192, 255'd1, (255'd1 << 192) - 255'd1, "ripple");
        do_op(255'd1 << 64, 255'd2, 255'h0_ffff_ffff_ffff_fffe, "limb1");

        // Start held while busy with changed operands, then held into the done cycle.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a_i   = 255'd10;
        bus.b_i   = 255'd4;
        @(negedge clk);
        bus.a_i = 255'd100;
        bus.b_i = 255'd1;
        for (int i = 0; i < 5; i++) begin
            chk("b2b_nodone1", 255'(bus.done), 255'd0);
            @(negedge clk);
        end
        chk("b2b_done1", 255'(bus.done), 255'd1);
        chk("b2b_out1", bus.out, 255'd6);
        bus.a_i = 255'd9;
        bus.b_i = 255'd2;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a_i   = 255'd0;
        bus.b_i   = 255'd0;
        for (int i = 0; i < 5; i++) begin
            chk("b2b_busy2", 255'(bus.busy), 255'd1);
            chk("b2b_nodone2", 255'(bus.done), 255'd0);
            chk("b2b_hold1", bus.out, 255'd6);
            @(negedge clk);
        end
        chk("b2b_done2", 255'(bus.done), 255'd1);
        chk("b2b_out2", bus.out, 255'd7);

        // Reset during S3 aborts the operation.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a_i   = 255'd50;
        bus.b_i   = 255'd20;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 255'(bus.busy), 255'd0);
        chk("abort_done", 255'(bus.done), 255'd0);
        chk("abort_out", bus.out, 255'd0);
        for (int i = 0; i < 6; i++) begin
            chk("abort_nodone", 255'(bus.done), 255'd0);
            chk("abort_out0", bus.out, 255'd0);
            @(negedge clk);
        end
        do_op(255'd7, 255'd2, 255'd5, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
